// File: rtl/ifu_bp_update_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ifu_bp_update_ctl
// Brief    : Branch-predictor update controller: BHT init sweep, update queue,
//            debug write port, fetch lookup and registered mispredict redirect.
//            Optional same-cycle/queued update bypass: BP_UPDATE_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ifu_bp_update_ctl #(
    parameter int BHT_DEPTH = 256,
    parameter int QDEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic                         exu_mp_valid,
    input  logic                         exu_mp_kill,
    input  logic [30:0]                  exu_mp_pc,
    input  logic [1:0]                   exu_mp_hist,
    input  logic                         exu_mp_misp,
    input  logic [30:0]                  exu_mp_path,
    input  logic                         dbg_wr_en,
    input  logic [$clog2(BHT_DEPTH)-1:0] dbg_wr_addr,
    input  logic [1:0]                   dbg_wr_data,
    input  logic [$clog2(BHT_DEPTH)-1:0] ifu_rd_addr,
    output logic [1:0]                   ifu_rd_hist,
    output logic                         ifu_redirect_valid,
    output logic [30:0]                  ifu_redirect_path,
    output logic                         bp_init_busy,
    output logic                         bp_q_full,
    output logic [7:0]                   bp_drop_cnt
);

    localparam int AW = $clog2(BHT_DEPTH);
    localparam int QW = $clog2(QDEPTH);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] sweep_q, sweep_d;
    logic [QW:0]   wr_ptr_q, wr_ptr_d;
    logic [QW:0]   rd_ptr_q, rd_ptr_d;
    logic [7:0]    drop_q, drop_d;
    logic          redir_valid_q, redir_valid_d;
    logic [30:0]   redir_path_q, redir_path_d;

    logic [1:0]    bht_q    [BHT_DEPTH];
    logic [AW-1:0] q_idx_q  [QDEPTH];
    logic [1:0]    q_hist_q [QDEPTH];

    logic          w_run, w_empty, w_full;
    logic          w_push_req, w_push, w_pop, w_drop, w_redir;
    logic [AW-1:0] w_push_idx;
    logic          w_bht_we;
    logic [AW-1:0] w_bht_waddr;
    logic [1:0]    w_bht_wdata;
    logic [1:0]    w_tbl_rd;
    logic          w_unused_pc;

    assign w_run      = (state_q == ST_RUN);
    assign w_push_idx = exu_mp_pc[AW-1:0];
    assign w_unused_pc = ^exu_mp_pc[30:AW];

    // Extra MSB on the pointers separates full from empty when low bits match.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[QW] != rd_ptr_q[QW]) &&
                     (wr_ptr_q[QW-1:0] == rd_ptr_q[QW-1:0]);

    assign w_push_req = exu_mp_valid & ~exu_mp_kill;
    assign w_pop      = w_run & ~w_empty & ~dbg_wr_en;
    assign w_push     = w_run & w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~w_push;
    assign w_redir    = exu_mp_valid & exu_mp_misp & ~exu_mp_kill;

    always_comb begin
        w_bht_we    = 1'b0;
        w_bht_waddr = '0;
        w_bht_wdata = 2'b00;
        if (!w_run) begin
            w_bht_we    = 1'b1;
            w_bht_waddr = sweep_q;
            w_bht_wdata = 2'b01;
        end else if (dbg_wr_en) begin
            w_bht_we    = 1'b1;
            w_bht_waddr = dbg_wr_addr;
            w_bht_wdata = dbg_wr_data;
        end else if (w_pop) begin
            w_bht_we    = 1'b1;
            w_bht_waddr = q_idx_q[rd_ptr_q[QW-1:0]];
            w_bht_wdata = q_hist_q[rd_ptr_q[QW-1:0]];
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (!w_run) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == AW'(BHT_DEPTH - 1)) begin
                state_d = ST_RUN;
            end
        end
        wr_ptr_d      = wr_ptr_q + {{QW{1'b0}}, w_push};
        rd_ptr_d      = rd_ptr_q + {{QW{1'b0}}, w_pop};
        drop_d        = (w_drop && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;
        redir_valid_d = w_redir;
        redir_path_d  = w_redir ? exu_mp_path : redir_path_q;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q       <= ST_INIT;
            sweep_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            drop_q        <= 8'h00;
            redir_valid_q <= 1'b0;
            redir_path_q  <= '0;
        end else begin
            state_q       <= state_d;
            sweep_q       <= sweep_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            drop_q        <= drop_d;
            redir_valid_q <= redir_valid_d;
            redir_path_q  <= redir_path_d;
        end
    end

    // Storage arrays carry no reset; validity comes from the sweep and pointers.
    always_ff @(posedge clk) begin
        if (w_bht_we) begin
            bht_q[w_bht_waddr] <= w_bht_wdata;
        end
        if (w_push) begin
            q_idx_q[wr_ptr_q[QW-1:0]]  <= w_push_idx;
            q_hist_q[wr_ptr_q[QW-1:0]] <= exu_mp_hist;
        end
    end

    assign w_tbl_rd = bht_q[ifu_rd_addr];

`ifdef BP_UPDATE_BYPASS_EN
    logic [QW:0]   w_cnt;
    logic [QW-1:0] w_slot;
    logic          w_byp_hit;
    logic [1:0]    w_byp_hist;

    assign w_cnt = wr_ptr_q - rd_ptr_q;

    // Walk oldest to youngest so the youngest match wins; the port write wins last.
    always_comb begin
        w_byp_hit  = 1'b0;
        w_byp_hist = 2'b00;
        w_slot     = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            w_slot = rd_ptr_q[QW-1:0] + QW'(i);
            if (((QW+1)'(i) < w_cnt) && (q_idx_q[w_slot] == ifu_rd_addr)) begin
                w_byp_hit  = 1'b1;
                w_byp_hist = q_hist_q[w_slot];
            end
        end
        if (w_bht_we && (w_bht_waddr == ifu_rd_addr)) begin
            w_byp_hit  = 1'b1;
            w_byp_hist = w_bht_wdata;
        end
    end

    assign ifu_rd_hist = !w_run ? 2'b00 : (w_byp_hit ? w_byp_hist : w_tbl_rd);
`else
    assign ifu_rd_hist = !w_run ? 2'b00 : w_tbl_rd;
`endif

    assign ifu_redirect_valid = redir_valid_q;
    assign ifu_redirect_path  = redir_path_q;
    assign bp_init_busy       = ~w_run;
    assign bp_q_full          = w_full;
    assign bp_drop_cnt        = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_ifu_bp_update_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_bp_update_ctl
// Brief    : Directed self-checking bench for ifu_bp_update_ctl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_bp_update_ctl;

    localparam int BHT_DEPTH = 256;
    localparam int QDEPTH    = 4;
`ifdef BP_UPDATE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_l;
    logic        exu_mp_valid, exu_mp_kill, exu_mp_misp;
    logic [30:0] exu_mp_pc, exu_mp_path;
    logic [1:0]  exu_mp_hist;
    logic        dbg_wr_en;
    logic [7:0]  dbg_wr_addr;
    logic [1:0]  dbg_wr_data;
    logic [7:0]  ifu_rd_addr;
    logic [1:0]  ifu_rd_hist;
    logic        ifu_redirect_valid;
    logic [30:0] ifu_redirect_path;
    logic        bp_init_busy, bp_q_full;
    logic [7:0]  bp_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ifu_bp_update_ctl #(.BHT_DEPTH(BHT_DEPTH), .QDEPTH(QDEPTH)) dut (
        .clk                (clk),
        .rst_l              (rst_l),
        .exu_mp_valid       (exu_mp_valid),
        .exu_mp_kill        (exu_mp_kill),
        .exu_mp_pc          (exu_mp_pc),
        .exu_mp_hist        (exu_mp_hist),
        .exu_mp_misp        (exu_mp_misp),
        .exu_mp_path        (exu_mp_path),
        .dbg_wr_en          (dbg_wr_en),
        .dbg_wr_addr        (dbg_wr_addr),
        .dbg_wr_data        (dbg_wr_data),
        .ifu_rd_addr        (ifu_rd_addr),
        .ifu_rd_hist        (ifu_rd_hist),
        .ifu_redirect_valid (ifu_redirect_valid),
        .ifu_redirect_path  (ifu_redirect_path),
        .bp_init_busy       (bp_init_busy),
        .bp_q_full          (bp_q_full),
        .bp_drop_cnt        (bp_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        exu_mp_valid = 1'b0;
        exu_mp_kill  = 1'b0;
        exu_mp_misp  = 1'b0;
        exu_mp_pc    = '0;
        exu_mp_hist  = 2'b00;
        exu_mp_path  = '0;
    endtask

    task automatic drive_br(input logic [7:0] idx, input logic [1:0] hist,
                            input logic misp, input logic [30:0] path, input logic kill);
        exu_mp_valid = 1'b1;
        exu_mp_kill  = kill;
        exu_mp_misp  = misp;
        exu_mp_pc    = {23'h0, idx};
        exu_mp_hist  = hist;
        exu_mp_path  = path;
    endtask

    task automatic rd(input string tag, input logic [7:0] addr, input logic [1:0] exp);
        ifu_rd_addr = addr;
        #1;
        chk(tag, 32'(ifu_rd_hist), 32'(exp));
    endtask

    task automatic chk_reset_outs(input string pfx);
        ifu_rd_addr = 8'h00;
        #1;
        chk({pfx, "_busy"},  32'(bp_init_busy), 32'd1);
        chk({pfx, "_full"},  32'(bp_q_full), 32'd0);
        chk({pfx, "_drop"},  32'(bp_drop_cnt), 32'd0);
        chk({pfx, "_rv"},    32'(ifu_redirect_valid), 32'd0);
        chk({pfx, "_rp"},    32'(ifu_redirect_path), 32'd0);
        chk({pfx, "_hist"},  32'(ifu_rd_hist), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] bp_hist [5];
        bp_hist[0] = 2'b11; bp_hist[1] = 2'b10; bp_hist[2] = 2'b00;
        bp_hist[3] = 2'b11; bp_hist[4] = 2'b10;

        rst_l       = 1'b0;
        dbg_wr_en   = 1'b0;
        dbg_wr_addr = 8'h00;
        dbg_wr_data = 2'b00;
        ifu_rd_addr = 8'h00;
        idle_in();
        #2;
        chk_reset_outs("rst0");

        // Init sweep: busy for exactly BHT_DEPTH edges after release
        @(posedge clk);
        #3 rst_l = 1'b1;
        repeat (BHT_DEPTH - 1) tick();
        chk("sweep_busy_255", 32'(bp_init_busy), 32'd1);
        rd("sweep_hist_forced0", 8'h40, 2'b00);
        tick();
        chk("sweep_busy_256", 32'(bp_init_busy), 32'd0);
        rd("sweep_rd_00", 8'h00, 2'b01);
        rd("sweep_rd_40", 8'h40, 2'b01);
        rd("sweep_rd_ff", 8'hFF, 2'b01);
        chk("sweep_drop", 32'(bp_drop_cnt), 32'd0);

        // Basic update
        drive_br(8'h40, 2'b11, 1'b0, 31'h0, 1'b0);
        tick();
        idle_in();
        rd("upd_edgeN", 8'h40, BYP ? 2'b11 : 2'b01);
        tick();
        rd("upd_edgeN1", 8'h40, 2'b11);
        chk("upd_no_redir", 32'(ifu_redirect_valid), 32'd0);

        // Redirect pulse, then killed branch
        drive_br(8'h20, 2'b10, 1'b1, 31'h1234, 1'b0);
        tick();
        idle_in();
        chk("redir_valid", 32'(ifu_redirect_valid), 32'd1);
        chk("redir_path", 32'(ifu_redirect_path), 32'h1234);
        tick();
        chk("redir_pulse_end", 32'(ifu_redirect_valid), 32'd0);
        chk("redir_path_hold", 32'(ifu_redirect_path), 32'h1234);
        rd("redir_upd_20", 8'h20, 2'b10);
        drive_br(8'h21, 2'b11, 1'b1, 31'h5555, 1'b1);
        tick();
        idle_in();
        chk("kill_no_redir", 32'(ifu_redirect_valid), 32'd0);
        chk("kill_path_hold", 32'(ifu_redirect_path), 32'h1234);
        tick();
        rd("kill_no_push", 8'h21, 2'b01);

        // Backpressure with debug write holding the port
        dbg_wr_en   = 1'b1;
        dbg_wr_addr = 8'h80;
        dbg_wr_data = 2'b00;
        for (int i = 0; i < 5; i++) begin
            drive_br(8'(i + 1), bp_hist[i], 1'b0, 31'h0, 1'b0);
            tick();
            chk($sformatf("bp_full_%0d", i), 32'(bp_q_full), (i >= 3) ? 32'd1 : 32'd0);
        end
        idle_in();
        chk("bp_drop1", 32'(bp_drop_cnt), 32'd1);
        rd("bp_dbg_wr", 8'h80, 2'b00);
        rd("bp_pending_01", 8'h01, BYP ? 2'b11 : 2'b01);
        dbg_wr_en = 1'b0;
        tick();
        chk("bp_full_after_pop", 32'(bp_q_full), 32'd0);
        repeat (3) tick();
        rd("bp_drain_01", 8'h01, 2'b11);
        rd("bp_drain_02", 8'h02, 2'b10);
        rd("bp_drain_03", 8'h03, 2'b00);
        rd("bp_drain_04", 8'h04, 2'b11);
        rd("bp_dropped_05", 8'h05, 2'b01);

        // Full queue, simultaneous pop and push
        dbg_wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_br(8'(8'h10 + i), 2'b10, 1'b0, 31'h0, 1'b0);
            tick();
        end
        chk("fpp_full_before", 32'(bp_q_full), 32'd1);
        dbg_wr_en = 1'b0;
        drive_br(8'h14, 2'b11, 1'b0, 31'h0, 1'b0);
        tick();
        idle_in();
        chk("fpp_full_after", 32'(bp_q_full), 32'd1);
        chk("fpp_no_drop", 32'(bp_drop_cnt), 32'd1);
        repeat (4) tick();
        chk("fpp_empty", 32'(bp_q_full), 32'd0);
        rd("fpp_rd_10", 8'h10, 2'b10);
        rd("fpp_rd_13", 8'h13, 2'b10);
        rd("fpp_rd_14", 8'h14, 2'b11);

        // Pending entries (bypass visibility), then reset mid-drain
        dbg_wr_en   = 1'b1;
        dbg_wr_addr = 8'h90;
        dbg_wr_data = 2'b11;
        drive_br(8'h30, 2'b10, 1'b0, 31'h0, 1'b0);
        tick();
        drive_br(8'h31, 2'b11, 1'b0, 31'h0, 1'b0);
        tick();
        drive_br(8'h32, 2'b00, 1'b1, 31'h4321, 1'b0);
        tick();
        idle_in();
        rd("byp_rd_30", 8'h30, BYP ? 2'b10 : 2'b01);
        rd("byp_rd_31", 8'h31, BYP ? 2'b11 : 2'b01);
        chk("pre_rst_rv", 32'(ifu_redirect_valid), 32'd1);
        rst_l     = 1'b0;
        dbg_wr_en = 1'b0;
        chk_reset_outs("rst1");
        @(posedge clk);
        #3 rst_l = 1'b1;
        tick();
        drive_br(8'h33, 2'b11, 1'b1, 31'h777, 1'b0);
        tick();
        idle_in();
        chk("init_redir_valid", 32'(ifu_redirect_valid), 32'd1);
        chk("init_redir_path", 32'(ifu_redirect_path), 32'h777);
        chk("init_drop", 32'(bp_drop_cnt), 32'd1);
        chk("init_busy", 32'(bp_init_busy), 32'd1);
        rd("init_hist0", 8'h33, 2'b00);
        repeat (BHT_DEPTH - 2) tick();
        chk("resweep_done", 32'(bp_init_busy), 32'd0);
        rd("resweep_30", 8'h30, 2'b01);
        rd("resweep_31", 8'h31, 2'b01);
        rd("resweep_32", 8'h32, 2'b01);
        rd("resweep_33", 8'h33, 2'b01);
        rd("resweep_40", 8'h40, 2'b01);
        chk("resweep_drop", 32'(bp_drop_cnt), 32'd1);
        chk("resweep_full", 32'(bp_q_full), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
